if_fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues sequential requests to a synchronous-read instruction memory. Returned words are buffered, each with its PC+4, in a small FIFO. The FIFO presents instructions to the decode stage over a valid/ready handshake. A single redirect input carries the branch/jump target resolved in MEM. It flushes the queue and any in-flight fetch, decoupling fetch from decode stalls.

---
 rtl/if_fetch_queue.sv | 135 +++++++++++++
 tb/tb_if_fetch_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential requests to a
// synchronous-read instruction memory and buffers {instruction, PC+4} pairs for decode.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     Clk,
    input  logic                     Rst,
    output logic                     IMemReq,
    output logic [31:0]              IMemAddr,
    input  logic [31:0]              IMemData,
    input  logic                     Redirect,
    input  logic [31:0]              RedirectPC,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [31:0]              OutInstruction,
    output logic [31:0]              OutPCAddResult,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   resp_pc4_q, resp_pc4_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc4_mem_q   [DEPTH];

    logic [CW:0]   used_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          valid_s;

    // Issue credit counts the outstanding fetch so a response always finds a free slot.
    always_comb begin
        used_s  = {1'b0, count_q} + (CW+1)'(inflight_q);
        issue_s = Rst && !Redirect && (used_s < (CW+1)'(DEPTH));
        valid_s = (count_q != {CW{1'b0}});
        pop_s   = valid_s && OutReady;
        push_s  = inflight_q && !Redirect;
    end

    // Head outputs read straight from the registered FIFO; zero while empty.
    always_comb begin
        IMemReq  = issue_s;
        IMemAddr = fetch_pc_q;
        OutValid = valid_s;
        Count    = count_q;
        if (valid_s) begin
            OutInstruction = instr_mem_q[head_q];
            OutPCAddResult = pc4_mem_q[head_q];
        end else begin
            OutInstruction = 32'h0000_0000;
            OutPCAddResult = 32'h0000_0000;
        end
    end

    // Next-state: redirect wipes the queue and any outstanding fetch before anything else.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        resp_pc4_d = resp_pc4_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (Redirect) begin
            fetch_pc_d = {RedirectPC[31:2], 2'b00};
            inflight_d = 1'b0;
            head_d     = {PW{1'b0}};
            tail_d     = {PW{1'b0}};
            count_d    = {CW{1'b0}};
        end else begin
            inflight_d = issue_s;
            if (issue_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                resp_pc4_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
                resp_pc4_d = resp_pc4_q;
            end
            if (pop_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            if (push_s) begin
                tail_d = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control state registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            resp_pc4_q <= 32'h0000_0000;
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            resp_pc4_q <= resp_pc4_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage, written at the tail when a response lands.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= 32'h0000_0000;
                pc4_mem_q[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            instr_mem_q[tail_q] <= IMemData;
            pc4_mem_q[tail_q]   <= resp_pc4_q;
        end else begin
            instr_mem_q[tail_q] <= instr_mem_q[tail_q];
            pc4_mem_q[tail_q]   <= pc4_mem_q[tail_q];
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed table and corner sequences plus randomized
// traffic, all checked against a queue-based reference model.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemData = 32'h0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] OutInstruction;
    logic [31:0] OutPCAddResult;
    logic [2:0]  Count;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk), .Rst(Rst), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemData(IMemData), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .OutValid(OutValid), .OutReady(OutReady), .OutInstruction(OutInstruction),
        .OutPCAddResult(OutPCAddResult), .Count(Count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    // Synchronous-read instruction memory: word[i] = i.
    always @(posedge Clk) begin
        if (IMemReq) IMemData <= mem_word(IMemAddr);
    end

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_fpc;
    logic        m_pend;
    logic [31:0] m_pend_addr;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc4;
    logic [2:0]  s_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc       = 32'h0000_0000;
        m_pend      = 1'b0;
        m_pend_addr = 32'h0;
    endtask

    // One clock cycle: drive inputs, sample and check at negedge, advance model, step past posedge.
    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
        logic   e_req;
        logic   e_valid;
        entry_t e;
        Redirect   = rd;
        RedirectPC = rpc;
        OutReady   = rdy;
        @(negedge Clk);
        s_req = IMemReq; s_addr = IMemAddr; s_valid = OutValid;
        s_instr = OutInstruction; s_pc4 = OutPCAddResult; s_count = Count;
        e_valid = (mq.size() != 0);
        e_req   = !rd && ((mq.size() + int'(m_pend)) < DEPTH);
        chk("model_req", {31'h0, s_req}, {31'h0, e_req});
        if (e_req) chk("model_addr", s_addr, m_fpc);
        chk("model_valid", {31'h0, s_valid}, {31'h0, e_valid});
        chk("model_count", {29'h0, s_count}, mq.size());
        if (e_valid) begin
            chk("model_instr", s_instr, mq[0].instr);
            chk("model_pc4", s_pc4, mq[0].pc4);
        end
        if (rd) begin
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = {rpc[31:2], 2'b00};
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (m_pend) begin
                e.instr = mem_word(m_pend_addr);
                e.pc4   = m_pend_addr + 32'd4;
                mq.push_back(e);
            end
            m_pend = e_req;
            if (e_req) begin
                m_pend_addr = m_fpc;
                m_fpc       = m_fpc + 32'd4;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        Redirect = 1'b0;
        OutReady = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [2:0]  e_count;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 3'd0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0, 32'h0, 3'd0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0, 32'h4, 3'd1};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h1, 32'h8, 3'd1};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h2, 32'hC, 3'd1};

        // Reset state before release.
        model_reset();
        @(posedge Clk);
        #1;
        chk("reset_req", {31'h0, IMemReq}, 32'h0);
        chk("reset_valid", {31'h0, OutValid}, 32'h0);
        chk("reset_count", {29'h0, Count}, 32'h0);
        chk("reset_instr", OutInstruction, 32'h0);
        chk("reset_pc4", OutPCAddResult, 32'h0);

        // Streaming from reset, table driven.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, vecs[i].rdy);
            chk("tbl_req", {31'h0, s_req}, {31'h0, vecs[i].e_req});
            chk("tbl_addr", s_addr, vecs[i].e_addr);
            chk("tbl_valid", {31'h0, s_valid}, {31'h0, vecs[i].e_valid});
            chk("tbl_instr", s_instr, vecs[i].e_instr);
            chk("tbl_pc4", s_pc4, vecs[i].e_pc4);
            chk("tbl_count", {29'h0, s_count}, {29'h0, vecs[i].e_count});
        end

        // Backpressure fills the queue, then drains one per cycle.
        do_reset();
        repeat (7) cycle(1'b0, 32'h0, 1'b0);
        chk("bp_count_full", {29'h0, s_count}, 32'd4);
        chk("bp_req_off", {31'h0, s_req}, 32'h0);
        chk("bp_head_instr", s_instr, 32'h0);
        chk("bp_head_pc4", s_pc4, 32'h4);
        cycle(1'b0, 32'h0, 1'b1);
        chk("bp_first_pop_req", {31'h0, s_req}, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("bp_resume_req", {31'h0, s_req}, 32'h1);
        chk("bp_resume_count", {29'h0, s_count}, 32'd3);
        chk("bp_second_instr", s_instr, 32'h1);
        chk("bp_second_pc4", s_pc4, 32'h8);

        // Redirect while a fetch is in flight; low target bits ignored.
        do_reset();
        repeat (4) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h0000_0103, 1'b1);
        chk("rd_no_issue", {31'h0, s_req}, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("rd_count0", {29'h0, s_count}, 32'h0);
        chk("rd_addr", s_addr, 32'h0000_0100);
        cycle(1'b0, 32'h0, 1'b1);
        chk("rd_valid_t2", {31'h0, s_valid}, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("rd_valid_t3", {31'h0, s_valid}, 32'h1);
        chk("rd_pc4_t3", s_pc4, 32'h0000_0104);
        chk("rd_instr_t3", s_instr, 32'h0000_0040);

        // Redirect coincident with a pop from a full queue.
        do_reset();
        repeat (7) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0200, 1'b1);
        chk("rdpop_valid", {31'h0, s_valid}, 32'h1);
        chk("rdpop_instr", s_instr, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("rdpop_count0", {29'h0, s_count}, 32'h0);
        chk("rdpop_addr", s_addr, 32'h0000_0200);
        cycle(1'b0, 32'h0, 1'b1);
        chk("rdpop_valid_t2", {31'h0, s_valid}, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("rdpop_instr_t3", s_instr, 32'h0000_0080);
        chk("rdpop_pc4_t3", s_pc4, 32'h0000_0204);

        // Fetch PC wrap at the top of the address space.
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("wrap_addr0", s_addr, 32'hFFFF_FFF8);
        cycle(1'b0, 32'h0, 1'b1);
        chk("wrap_addr1", s_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b1);
        chk("wrap_addr2", s_addr, 32'h0000_0000);
        chk("wrap_pc4_first", s_pc4, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b1);
        chk("wrap_pc4_second", s_pc4, 32'h0000_0000);
        chk("wrap_instr_second", s_instr, 32'h3FFF_FFFF);

        // Asynchronous reset mid-stream with three entries queued.
        do_reset();
        repeat (4) cycle(1'b0, 32'h0, 1'b0);
        chk("arst_pre_count", {29'h0, Count}, 32'd3);
        #2;
        Rst = 1'b0;
        #1;
        chk("arst_valid", {31'h0, OutValid}, 32'h0);
        chk("arst_count", {29'h0, Count}, 32'h0);
        chk("arst_req", {31'h0, IMemReq}, 32'h0);
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        chk("arst_restart_req", {31'h0, s_req}, 32'h1);
        chk("arst_restart_addr", s_addr, 32'h0000_0000);

        // Randomized traffic with varying backpressure and occasional redirects.
        for (int seg = 0; seg < 8; seg++) begin
            int ready_pct;
            ready_pct = $urandom_range(10, 100);
            for (int c = 0; c < 60; c++) begin
                logic rd;
                logic rdy;
                rd  = ($urandom_range(0, 15) == 0);
                rdy = ($urandom_range(1, 100) <= ready_pct);
                cycle(rd, $urandom, rdy);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
